uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one uart_transmitter between NUM_REQ byte producers. It arbitrates pending requests and latches the winning byte. It drives tx_start/tx_data into the transmitter, tracks the frame to completion via tx_done, then re-arbitrates. It sits between the producer blocks and the transmitter and shares the same baud_tick.

---
 rtl/uart_tx_scheduler.sv | 125 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_transmitter between NUM_REQ byte producers.
// Define UART_TX_SCHED_TIMEOUT_EN to add the BUSY watchdog (tmo_err); otherwise tmo_err is tied 0.
module uart_tx_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int TMO_TICKS = 12
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 baud_tick,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 sent,
  output logic                 tmo_err
);

  typedef enum logic [2:0] {SYNC, IDLE, LAUNCH, BUSY, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] winner_inc;
  logic            found;
  logic            tmo_hit;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ ||
      TMO_TICKS < 1 || TMO_TICKS > 15) begin : g_bad_cfg
    $error("uart_tx_scheduler: unsupported parameter combination");
  end

  // Two passes give the first requester at or above rr_ptr, else wrap to the lowest one.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i >= 32'(rr_ptr))) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
  end

  assign winner_inc = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (baud_tick && !tx_done) state_nxt = IDLE;
      IDLE:    if (found)                 state_nxt = LAUNCH;
      LAUNCH:  if (baud_tick)             state_nxt = BUSY;
      BUSY: begin
        if (tx_done)      state_nxt = DRAIN;
        else if (tmo_hit) state_nxt = SYNC;
      end
      DRAIN:   if (baud_tick && !tx_done) state_nxt = IDLE;
      default:                            state_nxt = SYNC;
    endcase
  end

  always_comb begin
    tx_start = (state == LAUNCH);
    busy     = (state == LAUNCH) || (state == BUSY) || (state == DRAIN);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      req_ready <= '0;
      tx_data   <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
      sent      <= 1'b0;
    end else begin
      req_ready <= '0;
      sent      <= (state == DRAIN) && baud_tick && !tx_done;
      if (state == IDLE && found) begin
        req_ready <= NUM_REQ'(1) << winner;
        tx_data   <= req_data[8*winner +: 8];
        grant_id  <= winner;
        rr_ptr    <= winner_inc;
      end
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [3:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == 4'(TMO_TICKS));

  // Counter is cleared while launching so it starts at zero on BUSY entry.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      if (state == LAUNCH)
        tmo_cnt <= '0;
      else if (state == BUSY && baud_tick)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (state == BUSY && !tx_done && tmo_hit)
        tmo_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural 8N1 transmitter on a 4-clock baud tick.
// Transmitter: idle -> 10 line bits (start, LSB-first data, stop) -> one done period -> idle.
module tb_uart_tx_scheduler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        baud_tick = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy, sent, tmo_err;

  uart_tx_scheduler #(.NUM_REQ(4), .ID_W(2), .TMO_TICKS(12)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .baud_tick(baud_tick), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .sent(sent), .tmo_err(tmo_err)
  );

  always #5 clock = ~clock;

  initial forever begin
    repeat (3) @(negedge clock);
    baud_tick = 1'b1;
    @(negedge clock);
    baud_tick = 1'b0;
  end

  int         ms = 0;
  int         bcnt = 0;
  logic [7:0] sh = '0;
  logic [9:0] fr = '0;
  logic       txd;
  logic       force_nodone = 1'b0;
  logic [9:0] frames[$];

  always_comb begin
    txd = 1'b1;
    if (ms == 1) begin
      if (bcnt == 0)      txd = 1'b0;
      else if (bcnt == 9) txd = 1'b1;
      else                txd = sh[bcnt-1];
    end
  end

  assign tx_done = (ms == 2) && !force_nodone;

  always @(posedge clock) begin
    if (baud_tick) begin
      case (ms)
        0: if (tx_start) begin sh <= tx_data; bcnt <= 0; ms <= 1; end
        1: begin
          fr[bcnt] <= txd;
          if (bcnt == 9) begin frames.push_back({txd, fr[8:0]}); ms <= 2; end
          else bcnt <= bcnt + 1;
        end
        default: ms <= 0;
      endcase
    end
  end

  int   sent_cnt = 0, bad_ready = 0, overlap = 0;
  int   grant_log[$];
  logic [7:0] data_log[$];
  logic busy_prev = 1'b0;

  always @(negedge clock) begin
    if (sent) sent_cnt++;
    if (req_ready != '0) begin
      if (!$onehot(req_ready) || busy_prev) bad_ready++;
      for (int i = 0; i < 4; i++) if (req_ready[i]) grant_log.push_back(i);
      data_log.push_back(tx_data);
    end
    if (tx_start && ms != 0) overlap++;
    busy_prev = busy;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  logic [3:0] hold_mask = '0, drop_on_sent = '0;

  task automatic step();
    @(negedge clock);
    req_valid = req_valid & ~(req_ready & ~hold_mask);
    if (sent) req_valid = req_valid & ~drop_on_sent;
  endtask

  task automatic wait_sent(input string tag, input int n, input int budget);
    int k = 0;
    while (sent_cnt < n && k < budget) begin step(); k++; end
    check(tag, sent_cnt, n);
  endtask

  task automatic wait_grants(input string tag, input int n, input int budget);
    int k = 0;
    while (grant_log.size() < n && k < budget) begin step(); k++; end
    check(tag, grant_log.size(), n);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_start"}, tx_start, 0);
    check({tag, "_data"}, tx_data, 0);
    check({tag, "_gid"}, grant_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sent"}, sent, 0);
    check({tag, "_tmo"}, tmo_err, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    int base, sbase, fbase, k;
    repeat (3) step();
    check_reset_vals("rst");
    reset_n = 1'b1;
    repeat (8) step();

    // Single request, 0xA5 from requester 0.
    req_data[7:0] = 8'hA5;
    req_valid[0] = 1'b1;
    step();
    check("t1_ready", req_ready, 4'b0001);
    check("t1_gid", grant_id, 0);
    check("t1_data", tx_data, 8'hA5);
    check("t1_busy", busy, 1);
    check("t1_start_hi", tx_start, 1);
    k = 0;
    while (tx_start && k < 6) begin step(); k++; end
    check("t1_start_drop", tx_start, 0);
    wait_sent("t1_sent", 1, 300);
    check("t1_nframes", frames.size(), 1);
    if (frames.size() > 0) check("t1_frame", frames[0], 10'h34A);
    check("t1_busy_clr", busy, 0);

    // All four at once after reset, then requester 2 alone.
    do_reset();
    base = grant_log.size();
    sbase = sent_cnt;
    req_data = 32'h44332211;
    req_valid = 4'hF;
    wait_sent("t2_sent4", sbase + 4, 1000);
    check("t2_ngrants", grant_log.size(), base + 4);
    if (grant_log.size() >= base + 4)
      for (int i = 0; i < 4; i++) begin
        check("t2_order", grant_log[base+i], i);
        check("t2_byte", data_log[base+i], 8'h11 * (i + 1));
      end
    req_valid[2] = 1'b1;
    wait_sent("t2_sent5", sbase + 5, 300);
    check("t2_ngrants5", grant_log.size(), base + 5);
    if (grant_log.size() >= base + 5) check("t2_only2", grant_log[base+4], 2);
    check("t2_frame2", frames[frames.size()-1], frame_of(8'h33));

    // Requester 1 held, requester 3 pulsed once: expect 1,3,1,1.
    base = grant_log.size();
    sbase = sent_cnt;
    hold_mask = 4'b0010;
    req_valid[1] = 1'b1;
    wait_grants("t3_first", base + 1, 100);
    req_valid[3] = 1'b1;
    wait_grants("t3_four", base + 4, 1000);
    hold_mask = '0;
    req_valid[1] = 1'b0;
    wait_sent("t3_sent", sbase + 4, 300);
    repeat (20) step();
    check("t3_ngrants", grant_log.size(), base + 4);
    if (grant_log.size() >= base + 4) begin
      check("t3_g0", grant_log[base],   1);
      check("t3_g1", grant_log[base+1], 3);
      check("t3_g2", grant_log[base+2], 1);
      check("t3_g3", grant_log[base+3], 1);
    end

    // Requester 2 withdraws just before it would win.
    base = grant_log.size();
    sbase = sent_cnt;
    req_data[7:0] = 8'h5E;
    req_data[23:16] = 8'hE2;
    req_valid[0] = 1'b1;
    wait_grants("t4_grant0", base + 1, 100);
    req_valid[2] = 1'b1;
    drop_on_sent = 4'b0100;
    wait_sent("t4_sent", sbase + 1, 300);
    repeat (60) step();
    drop_on_sent = '0;
    check("t4_no_grant2", grant_log.size(), base + 1);
    check("t4_no_frame", sent_cnt, sbase + 1);

    // Reset mid-frame: outputs clear, abandoned frame finishes, next one is clean.
    req_data[7:0] = 8'h3C;
    req_valid[0] = 1'b1;
    k = 0;
    while (!(ms == 1 && bcnt == 4) && k < 200) begin step(); k++; end
    check("t5_busy_mid", busy, 1);
    sbase = sent_cnt;
    fbase = frames.size();
    reset_n = 1'b0;
    step();
    check_reset_vals("t5_rst");
    reset_n = 1'b1;
    k = 0;
    while (ms != 0 && k < 200) begin step(); k++; end
    check("t5_nframes", frames.size(), fbase + 1);
    check("t5_old_frame", frames[frames.size()-1], frame_of(8'h3C));
    check("t5_no_sent", sent_cnt, sbase);
    req_data[15:8] = 8'h5A;
    req_valid[1] = 1'b1;
    wait_sent("t5_sent", sbase + 1, 300);
    check("t5_new_frame", frames[frames.size()-1], frame_of(8'h5A));

    // Reset while the transmitter reports done, with a request already pending.
    req_data[7:0] = 8'h81;
    req_valid[0] = 1'b1;
    k = 0;
    while (ms != 2 && k < 300) begin step(); k++; end
    sbase = sent_cnt;
    req_data[31:24] = 8'hC3;
    req_valid[3] = 1'b1;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    wait_sent("t6_sent", sbase + 1, 400);
    check("t6_frame", frames[frames.size()-1], frame_of(8'hC3));
    check("t6_gid", grant_id, 3);

    // tx_done never arrives.
    force_nodone = 1'b1;
    sbase = sent_cnt;
    req_data[7:0] = 8'h77;
    req_valid[0] = 1'b1;
    repeat (120) step();
    check("t7_no_sent", sent_cnt, sbase);
`ifdef UART_TX_SCHED_TIMEOUT_EN
    check("t7_busy", busy, 0);
    check("t7_tmo", tmo_err, 1);
`else
    check("t7_busy", busy, 1);
    check("t7_tmo", tmo_err, 0);
`endif
    force_nodone = 1'b0;
    do_reset();
    check("t7_tmo_rst", tmo_err, 0);

    check("no_grant_while_busy", bad_ready, 0);
    check("start_while_tx_busy", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
